laplacian_frame_sequencer: RTL and testbench

//  Frame-level controller in front of the 3x3 Laplacian core. Accepts one grey frame over a valid/ready

---
 rtl/laplacian_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_laplacian_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laplacian_frame_sequencer.sv
// Frame-level controller for the 3x3 Laplacian core: paces source pixels into the core,
// flushes its line buffers with zeros, and re-emits in-frame results in raster order.
module laplacian_frame_sequencer #(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240,
  parameter int PIXEL_GAP     = 4,
  parameter int FLUSH_COUNT   = 322,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] drop_count,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        core_gray_valid,
  output logic [7:0]  core_gray,
  input  logic        core_lap_valid,
  input  logic [7:0]  core_lap_out,
  input  logic [31:0] core_center_row,
  input  logic [31:0] core_center_col,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic [15:0] m_row,
  output logic [15:0] m_col,
  output logic        m_last
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int GW   = (PIXEL_GAP > 1) ? $clog2(PIXEL_GAP) : 1;
  localparam int FW   = (FLUSH_COUNT > 1) ? $clog2(FLUSH_COUNT + 1) : 1;
  localparam int TW   = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [GW-1:0]   gap_cnt;
  logic [IW-1:0]   in_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [TW-1:0]   drain_cnt;
  logic [IW-1:0]   out_idx;

  logic            capture_en;
  logic            row_ok;
  logic            col_ok;
  logic [31:0]     res_idx;
  logic            accept;
  logic            drop;

  assign busy    = (state != S_IDLE);
  assign s_ready = (state == S_FEED) && (gap_cnt == '0);

  // Signed coordinates: bit31 set means the centre lies above/left of the frame.
  always_comb begin
    capture_en = (state == S_FEED) || (state == S_FLUSH) || (state == S_DRAIN);
    row_ok     = !core_center_row[31] && (core_center_row < 32'(IMAGE_HEIGHT));
    col_ok     = !core_center_col[31] && (core_center_col < 32'(IMAGE_WIDTH));
    res_idx    = core_center_row * 32'(IMAGE_WIDTH) + core_center_col;
    accept     = capture_en && core_lap_valid && row_ok && col_ok && (res_idx == 32'(out_idx));
    drop       = capture_en && core_lap_valid && row_ok && col_ok && (res_idx != 32'(out_idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      gap_cnt         <= '0;
      in_cnt          <= '0;
      flush_cnt       <= '0;
      drain_cnt       <= '0;
      out_idx         <= '0;
      frame_done      <= 1'b0;
      timeout_err     <= 1'b0;
      drop_count      <= '0;
      core_gray_valid <= 1'b0;
      core_gray       <= '0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_row           <= '0;
      m_col           <= '0;
      m_last          <= 1'b0;
    end else begin
      core_gray_valid <= 1'b0;
      m_valid         <= 1'b0;
      m_last          <= 1'b0;
      frame_done      <= 1'b0;

      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= core_lap_out;
        m_row   <= core_center_row[15:0];
        m_col   <= core_center_col[15:0];
        m_last  <= (res_idx == 32'(NPIX - 1));
        out_idx <= out_idx + IW'(1);
      end
      if (drop && (drop_count != '1))
        drop_count <= drop_count + 16'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FEED;
            gap_cnt     <= '0;
            in_cnt      <= '0;
            flush_cnt   <= '0;
            drain_cnt   <= '0;
            out_idx     <= '0;
            drop_count  <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_FEED: begin
          if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
          if (s_valid && s_ready) begin
            core_gray_valid <= 1'b1;
            core_gray       <= s_data;
            gap_cnt         <= GW'(PIXEL_GAP - 1);
            in_cnt          <= in_cnt + IW'(1);
            if (in_cnt == IW'(NPIX - 1))
              state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else begin
            core_gray_valid <= 1'b1;
            core_gray       <= '0;
            gap_cnt         <= GW'(PIXEL_GAP - 1);
            flush_cnt       <= flush_cnt + FW'(1);
            if (flush_cnt == FW'(FLUSH_COUNT - 1)) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (out_idx == IW'(NPIX)) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
            state       <= S_DONE;
            frame_done  <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + TW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laplacian_frame_sequencer.sv
// Bench for laplacian_frame_sequencer: a stub core answers each strobe with a chosen centre,
// and monitors check strobe cadence, flush data and the output raster stream.
module tb_laplacian_frame_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int GAP  = 4;
  localparam int FL   = 8;
  localparam int TO   = 64;
  localparam int NPIX = W * H;
  localparam int LAT  = W + 1;

  logic        clk, rst_n, start;
  logic        busy, frame_done, timeout_err;
  logic [15:0] drop_count;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        core_gray_valid;
  logic [7:0]  core_gray;
  logic        core_lap_valid;
  logic [7:0]  core_lap_out;
  logic [31:0] core_center_row, core_center_col;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] m_row, m_col;
  logic        m_last;

  laplacian_frame_sequencer #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PIXEL_GAP    (GAP),
    .FLUSH_COUNT  (FL),
    .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .frame_done     (frame_done),
    .timeout_err    (timeout_err),
    .drop_count     (drop_count),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .core_gray_valid(core_gray_valid),
    .core_gray      (core_gray),
    .core_lap_valid (core_lap_valid),
    .core_lap_out   (core_lap_out),
    .core_center_row(core_center_row),
    .core_center_col(core_center_col),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_row          (m_row),
    .m_col          (m_col),
    .m_last         (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'(100 + 3 * i);
  endfunction

  function automatic logic [7:0] lap_val(input int c);
    return 8'(c * 7 + 3);
  endfunction

  // Scenario selection shared by stub and monitor
  int cur_mode  = 0;
  bit cur_stall = 1'b0;
  int frame_gen = 0;

  // Stub core: result for strobe k centres on pixel k-LAT; mode 3 reorders, mode 4 withholds the last.
  int seq3 [14] = '{0, 1, 2, 2, 4, 3, 4, 5, 6, 7, 8, 9, 10, 11};
  int stub_k;
  always @(posedge clk or negedge rst_n) begin : stub_core
    int sc, sj;
    bit emit;
    if (!rst_n) begin
      stub_k          <= 0;
      core_lap_valid  <= 1'b0;
      core_lap_out    <= '0;
      core_center_row <= '0;
      core_center_col <= '0;
    end else begin
      core_lap_valid <= 1'b0;
      if (frame_done) begin
        stub_k <= 0;
      end else if (core_gray_valid) begin
        stub_k <= stub_k + 1;
        emit = 1'b1;
        if (cur_mode == 3) begin
          sj = stub_k - LAT;
          if (sj >= 0 && sj < 14) sc = seq3[sj];
          else begin sc = -1; emit = 1'b0; end
        end else begin
          sc = stub_k - LAT;
          if (cur_mode == 4 && sc == NPIX - 1) emit = 1'b0;
        end
        core_lap_valid <= emit;
        core_lap_out   <= lap_val(sc);
        if (sc < 0) begin
          core_center_row <= 32'hFFFF_FFFF;
          core_center_col <= 32'd0;
        end else begin
          core_center_row <= 32'(sc / W);
          core_center_col <= 32'(sc % W);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int seen_gen = 0;
  int str_k, last_str, out_cnt, done_cnt, t_drain, t_to;
  bit to_prev;

  always @(negedge clk) begin : monitor
    int gap;
    if (seen_gen != frame_gen) begin
      seen_gen = frame_gen;
      str_k = 0; last_str = 0; out_cnt = 0; done_cnt = 0;
      t_drain = -1; t_to = -1; to_prev = timeout_err;
    end
    if (rst_n) begin
      if (core_gray_valid) begin
        if (str_k > 0) begin
          gap = cyc - last_str;
          if (cur_stall) check("strobe_gap_min", 64'(gap >= GAP), 64'd1);
          else           check("strobe_gap", 64'(gap), 64'(GAP));
        end
        if (str_k < NPIX) check("strobe_pixel", 64'(core_gray), 64'(pix(str_k)));
        else              check("flush_zero", 64'(core_gray), 64'd0);
        if (str_k == NPIX + FL - 1) t_drain = cyc;
        last_str = cyc;
        str_k++;
      end
      if (m_valid) begin
        if (out_cnt >= NPIX) begin
          check("extra_output", 64'd1, 64'd0);
        end else begin
          check("m_row", 64'(m_row), 64'(out_cnt / W));
          check("m_col", 64'(m_col), 64'(out_cnt % W));
          check("m_data", 64'(m_data), 64'(lap_val(out_cnt)));
          check("m_last", 64'(m_last), 64'(out_cnt == NPIX - 1));
        end
        out_cnt++;
      end
      if (frame_done) done_cnt++;
      if (timeout_err && !to_prev) t_to = cyc;
      to_prev = timeout_err;
    end
  end

  // Pushes pixels 0..npix-1; stall mode adds random s_valid gaps and start pulses while busy.
  task automatic drive_frame(input int npix, input bit stall);
    int i = 0;
    int budget = 0;
    while (i < npix && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (stall && ($urandom_range(2) == 0)) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = pix(i);
      end
      start = stall && busy && ($urandom_range(4) == 0);
      if (s_valid && s_ready) i++;
    end
    if (i < npix) check("feed_budget", 64'd0, 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  typedef struct {
    int mode;
    bit stall;
    int exp_out;
    int exp_drop;
    bit exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic run_frame(input vec_t v);
    int n = 0;
    frame_gen++;
    cur_mode  = v.mode;
    cur_stall = v.stall;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_clears", {47'd0, timeout_err, drop_count}, 64'd0);
    drive_frame(NPIX, v.stall);
    while (!frame_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) check("frame_done_wait", 64'd0, 64'd1);
    check("timeout_err", 64'(timeout_err), 64'(v.exp_to));
    check("drop_count", 64'(drop_count), 64'(v.exp_drop));
    repeat (6) @(negedge clk);
    check("out_count", 64'(out_cnt), 64'(v.exp_out));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("strobe_count", 64'(str_k), 64'(NPIX + FL));
    check("idle_busy", 64'(busy), 64'd0);
    if (v.exp_to) check("timeout_latency", 64'(t_to - t_drain), 64'(TO));
  endtask

  initial begin
    int d0;
    vecs[0] = '{mode: 0, stall: 1'b0, exp_out: 12, exp_drop: 0, exp_to: 1'b0};
    vecs[1] = '{mode: 3, stall: 1'b0, exp_out: 12, exp_drop: 2, exp_to: 1'b0};
    vecs[2] = '{mode: 4, stall: 1'b0, exp_out: 11, exp_drop: 0, exp_to: 1'b1};
    vecs[3] = '{mode: 0, stall: 1'b1, exp_out: 12, exp_drop: 0, exp_to: 1'b0};
    vecs[4] = '{mode: 3, stall: 1'b1, exp_out: 12, exp_drop: 2, exp_to: 1'b0};

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, frame_done, timeout_err, drop_count, s_ready, core_gray_valid, core_gray,
           m_valid, m_data, m_row, m_last}, 64'd0);
    check("reset_m_col", 64'(m_col), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Reset in the middle of FEED abandons the frame silently
    frame_gen++;
    cur_mode = 0; cur_stall = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    drive_frame(5, 1'b0);
    @(negedge clk);
    check("midfeed_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {busy, frame_done, timeout_err, drop_count, s_ready, core_gray_valid, core_gray,
           m_valid, m_data, m_row, m_last}, 64'd0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt), 64'(d0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
